// File: rtl/palette_ctrl.sv
// palette_ctrl: writable 8-entry RRGGBB palette for the VGA pixel path, with an
// optional frame-synchronous colour-cycling sequencer.
//
// Build option: define PALETTE_CYCLE_EN to include the frame counter, rotation
// FSM and host/rotation arbitration. Without it the block is a plain writable
// palette: cycle_en and vsync_start are ignored and busy is tied low.
//
// Parameters:
//   FRAMES_PER_STEP  vsync_start pulses between rotation steps (>= 1)
//   CYCLE_LO         lowest palette index of the rotating band
//   CYCLE_HI         highest palette index of the rotating band (LO < HI <= 7)
//
// Ports:
//   clk          pixel clock
//   reset        synchronous, active-high; reloads the default palette
//   color_index  pixel colour index, looked up every cycle
//   rrggbb       registered colour for color_index (1-cycle latency)
//   vsync_start  single-cycle pulse at the start of vertical blanking
//   vblank       high during vertical blanking; host writes only land here
//   wr_valid     host write request (held until accepted)
//   wr_ready     host write accepted when high together with wr_valid
//   wr_addr      palette index to write
//   wr_data      RRGGBB value to write
//   cycle_en     enables colour cycling
//   busy         high while a rotation is in progress
module palette_ctrl #(
    parameter int FRAMES_PER_STEP = 8,
    parameter int CYCLE_LO        = 1,
    parameter int CYCLE_HI        = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] color_index,
    output logic [5:0] rrggbb,
    input  logic       vsync_start,
    input  logic       vblank,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_addr,
    input  logic [5:0] wr_data,
    input  logic       cycle_en,
    output logic       busy
);

    localparam logic [2:0] LO = 3'(CYCLE_LO);
    localparam logic [2:0] HI = 3'(CYCLE_HI);

    function automatic logic [5:0] dflt(input int i);
        case (i)
            0:       dflt = 6'b111000;
            1:       dflt = 6'b110110;
            2:       dflt = 6'b101101;
            3:       dflt = 6'b111000;
            4:       dflt = 6'b110011;
            5:       dflt = 6'b011111;
            6:       dflt = 6'b001011;
            default: dflt = 6'b000000;
        endcase
    endfunction

    logic [5:0] pal [8];

    // Single palette write port, shared by the host and the rotation engine.
    logic       pal_we;
    logic [2:0] pal_wa;
    logic [5:0] pal_wd;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) pal[i] <= dflt(i);
        end else if (pal_we) begin
            pal[pal_wa] <= pal_wd;
        end
    end

    // Lookup reads the pre-write contents: no write-to-read bypass.
    always_ff @(posedge clk) begin
        if (reset) rrggbb <= '0;
        else       rrggbb <= pal[color_index];
    end

`ifdef PALETTE_CYCLE_EN

    localparam int FCW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [FCW-1:0] FLAST = FCW'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;

    state_t         state, state_nxt;
    logic [FCW-1:0] fcnt;
    logic           rot_trigger;
    logic [2:0]     ptr;
    logic [5:0]     tmp;

    assign rot_trigger = cycle_en & vsync_start & (fcnt == FLAST);

    // Frame counter keeps counting during a rotation; a trigger that lands
    // outside IDLE is simply not acted on by the FSM.
    always_ff @(posedge clk) begin
        if (reset || !cycle_en) fcnt <= '0;
        else if (vsync_start)   fcnt <= (fcnt == FLAST) ? '0 : fcnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rot_trigger) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (ptr == LO + 3'd1) state_nxt = STORE;
            STORE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // tmp holds the top band entry while the rest of the band shifts up by one.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmp <= '0;
            ptr <= '0;
        end else begin
            case (state)
                LOAD: begin
                    tmp <= pal[HI];
                    ptr <= HI;
                end
                SHIFT:   ptr <= ptr - 3'd1;
                default: ;
            endcase
        end
    end

    // Rotation owns the write port outside IDLE and in the trigger cycle.
    always_comb begin
        busy     = (state != IDLE);
        wr_ready = vblank & ~reset & (state == IDLE) & ~rot_trigger;
        pal_we   = 1'b0;
        pal_wa   = '0;
        pal_wd   = '0;
        case (state)
            IDLE: begin
                if (wr_valid && wr_ready) begin
                    pal_we = 1'b1;
                    pal_wa = wr_addr;
                    pal_wd = wr_data;
                end
            end
            SHIFT: begin
                pal_we = 1'b1;
                pal_wa = ptr;
                pal_wd = pal[ptr - 3'd1];
            end
            STORE: begin
                pal_we = 1'b1;
                pal_wa = LO;
                pal_wd = tmp;
            end
            default: ;
        endcase
    end

`else

    // Plain writable palette: sequencer inputs and band settings have no effect.
    logic unused_cfg;
    assign unused_cfg = ^{cycle_en, vsync_start, LO, HI, (FRAMES_PER_STEP > 0)};

    assign busy     = 1'b0;
    assign wr_ready = vblank & ~reset;
    assign pal_we   = wr_valid & wr_ready;
    assign pal_wa   = wr_addr;
    assign pal_wd   = wr_data;

`endif

endmodule

// File: tb/tb_palette_ctrl.sv
module tb_palette_ctrl;

    localparam int FPS     = 2;
    localparam int LO      = 1;
    localparam int HI      = 6;
    localparam int ROT_LEN = HI - LO + 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] color_index;
    logic [5:0] rrggbb;
    logic       vsync_start;
    logic       vblank;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_addr;
    logic [5:0] wr_data;
    logic       cycle_en;
    logic       busy;

    always #5 clk = ~clk;

    palette_ctrl #(
        .FRAMES_PER_STEP(FPS),
        .CYCLE_LO       (LO),
        .CYCLE_HI       (HI)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .color_index(color_index),
        .rrggbb     (rrggbb),
        .vsync_start(vsync_start),
        .vblank     (vblank),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cycle_en   (cycle_en),
        .busy       (busy)
    );

    typedef struct {
        logic [2:0] idx;
        logic [5:0] exp;
    } vec_t;

    // Expected palettes: defaults, after one rotation, after a second rotation
    // followed by the host write of 000111 to index 3.
    logic [5:0] dflt_c [8] = '{6'b111000, 6'b110110, 6'b101101, 6'b111000,
                               6'b110011, 6'b011111, 6'b001011, 6'b000000};
    logic [5:0] rot1_c [8] = '{6'b111000, 6'b001011, 6'b110110, 6'b101101,
                               6'b111000, 6'b110011, 6'b011111, 6'b000000};
    logic [5:0] rot2_c [8] = '{6'b111000, 6'b011111, 6'b001011, 6'b000111,
                               6'b101101, 6'b111000, 6'b110011, 6'b000000};

    vec_t dtab [8];
    vec_t rtab [8];
    vec_t ctab [8];

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model for the random phase.
    logic [5:0] mpal [8];
    int         mfcnt;
    int         mbusy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic pulse_vsync();
        vsync_start = 1'b1;
        cyc();
        vsync_start = 1'b0;
    endtask

    task automatic sweep(input string nm, input int which);
        vec_t v;
        for (int i = 0; i < 8; i++) begin
            case (which)
                0:       v = dtab[i];
                1:       v = rtab[i];
                default: v = ctab[i];
            endcase
            color_index = v.idx;
            cyc();
            chk($sformatf("%s[%0d]", nm, i), {26'd0, rrggbb}, {26'd0, v.exp});
        end
    endtask

    // Whole-band rotation applied in one step: band moves up, top wraps to bottom.
    function automatic void rot_model();
        logic [5:0] top;
        top = mpal[HI];
        for (int i = HI; i > LO; i--) mpal[i] = mpal[i-1];
        mpal[LO] = top;
    endfunction

    task automatic rcycle(input logic vb, input logic vs);
        logic       trig, exp_rdy, skip, acc;
        logic [5:0] exp_rd;
        vblank      = vb;
        vsync_start = vs;
        color_index = 3'($urandom_range(0, 7));
        if (!wr_valid && $urandom_range(0, 2) == 0) begin
            wr_valid = 1'b1;
            wr_addr  = 3'($urandom_range(0, 7));
            wr_data  = 6'($urandom_range(0, 63));
        end
        #1;
`ifdef PALETTE_CYCLE_EN
        trig    = cycle_en && vs && (mfcnt == FPS - 1);
        exp_rdy = vb && (mbusy == 0) && !trig;
`else
        trig    = 1'b0;
        exp_rdy = vb;
`endif
        chk("rnd_wr_ready", {31'd0, wr_ready}, {31'd0, exp_rdy});
        chk("rnd_busy", {31'd0, busy}, {31'd0, mbusy != 0});
        exp_rd = mpal[color_index];
        // Band entries are mid-shuffle while a rotation runs.
        skip = (mbusy != 0) && (int'(color_index) >= LO) && (int'(color_index) <= HI);
        acc  = wr_valid && exp_rdy;
        if (acc) mpal[wr_addr] = wr_data;
        if (!cycle_en)  mfcnt = 0;
        else if (vs)    mfcnt = (mfcnt == FPS - 1) ? 0 : mfcnt + 1;
        if (mbusy != 0) begin
            mbusy--;
            if (mbusy == 0) rot_model();
        end else if (trig) begin
            mbusy = ROT_LEN;
        end
        cyc();
        if (!skip) chk("rnd_rrggbb", {26'd0, rrggbb}, {26'd0, exp_rd});
        if (acc) wr_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nb;
        for (int i = 0; i < 8; i++) begin
            dtab[i] = '{idx: 3'(i), exp: dflt_c[i]};
            rtab[i] = '{idx: 3'(i), exp: rot1_c[i]};
            ctab[i] = '{idx: 3'(i), exp: rot2_c[i]};
        end

        reset       = 1'b1;
        color_index = '0;
        vsync_start = 1'b0;
        vblank      = 1'b1;
        wr_valid    = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        cycle_en    = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        chk("reset_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("reset_rrggbb", {26'd0, rrggbb}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        sweep("default", 0);

        // Host write held outside vblank, lands in the first vblank cycle
        do_reset();
        vblank   = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 3'd7;
        wr_data  = 6'b101010;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_wr_ready", {31'd0, wr_ready}, 32'd0);
            cyc();
        end
        vblank = 1'b1;
        #1;
        chk("vblank_wr_ready", {31'd0, wr_ready}, 32'd1);
        cyc();
        wr_valid    = 1'b0;
        color_index = 3'd7;
        cyc();
        chk("write_idx7", {26'd0, rrggbb}, {26'd0, 6'b101010});

`ifdef PALETTE_CYCLE_EN
        // Rotation after FPS vsync pulses
        do_reset();
        cycle_en = 1'b1;
        pulse_vsync();
        cyc();
        vsync_start = 1'b1;
        #1;
        chk("trig_wr_ready", {31'd0, wr_ready}, 32'd0);
        cyc();
        vsync_start = 1'b0;
        for (int k = 0; k < ROT_LEN + 2; k++) begin
            chk($sformatf("rot_busy[%0d]", k), {31'd0, busy}, {31'd0, k < ROT_LEN});
            cyc();
        end
        sweep("rot1", 1);

        // Host write in the trigger cycle waits for the rotation to finish
        pulse_vsync();
        cyc();
        vsync_start = 1'b1;
        wr_valid    = 1'b1;
        wr_addr     = 3'd3;
        wr_data     = 6'b000111;
        #1;
        chk("coll_trig_wr_ready", {31'd0, wr_ready}, 32'd0);
        cyc();
        vsync_start = 1'b0;
        for (int k = 0; k <= ROT_LEN; k++) begin
            #1;
            chk($sformatf("coll_wr_ready[%0d]", k), {31'd0, wr_ready}, {31'd0, k == ROT_LEN});
            cyc();
        end
        wr_valid = 1'b0;
        sweep("rot2_write", 2);

        // Reset during SHIFT, with the frame counter part-way through a step
        pulse_vsync();
        cyc();
        pulse_vsync();
        cyc();
        pulse_vsync();
        chk("shift_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        cyc();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        sweep("abort_default", 0);
        pulse_vsync();
        for (int k = 0; k < 3; k++) begin
            chk("fcnt_restart_idle", {31'd0, busy}, 32'd0);
            cyc();
        end
        pulse_vsync();
        chk("fcnt_restart_rot", {31'd0, busy}, 32'd1);
        for (int k = 0; k < ROT_LEN + 1; k++) cyc();
`else
        // Plain palette: vsync and cycle_en have no effect
        do_reset();
        cycle_en = 1'b1;
        for (int p = 0; p < 16; p++) begin
            vsync_start = 1'b1;
            #1;
            chk("plain_busy_vs", {31'd0, busy}, 32'd0);
            chk("plain_wr_ready", {31'd0, wr_ready}, 32'd1);
            cyc();
            vsync_start = 1'b0;
            chk("plain_busy", {31'd0, busy}, 32'd0);
            cyc();
        end
        sweep("plain_default", 0);
`endif

        // Randomized frames against the model
        do_reset();
        for (int i = 0; i < 8; i++) mpal[i] = dflt_c[i];
        mfcnt = 0;
        mbusy = 0;
        for (int f = 0; f < 16; f++) begin
            cycle_en = ($urandom_range(0, 4) != 0);
            na = $urandom_range(3, 8);
            for (int c = 0; c < na; c++) rcycle(1'b0, 1'b0);
            nb = $urandom_range(10, 14);
            for (int c = 0; c < nb; c++) begin
                if (c == 3 && $urandom_range(0, 3) == 0) cycle_en = 1'b0;
                rcycle(1'b1, c == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/palette_ctrl.md
# palette_ctrl

Writable 8-entry, 6-bit RRGGBB palette with a built-in colour-cycling sequencer for the VGA pixel pipeline. It replaces a fixed colour lookup. A host write port and a frame-synchronous rotation engine share the single palette write port. All palette modifications are confined to vertical blanking so the visible frame never tears. The pixel path reads the palette every cycle with fixed latency.

## Interface
- `FRAMES_PER_STEP`, default 8: number of `vsync_start` pulses between rotation steps; must be ≥1.
- `CYCLE_LO`, default 1: lowest palette index in the rotating band.
- `CYCLE_HI`, default 6: highest palette index in the rotating band.
- Parameter constraint: 0 ≤ `CYCLE_LO` < `CYCLE_HI` ≤ 7.

- `clk` in 1: pixel clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `color_index` in 3: pixel colour index.
- `rrggbb` out 6: registered colour for `color_index`.
- `vsync_start` in 1: single-cycle pulse at the start of vertical blanking.
- `vblank` in 1: high throughout vertical blanking.
- `wr_valid` in 1: host write request.
- `wr_ready` out 1: host write accepted this cycle when high together with `wr_valid`.
- `wr_addr` in 3: palette index to write.
- `wr_data` in 6: RRGGBB value to write.
- `cycle_en` in 1: enables colour cycling.
- `busy` out 1: high while a rotation is in progress.

## Operation
- Palette defaults, loaded at reset:
  - index 0: 111000
  - index 1: 110110
  - index 2: 101101
  - index 3: 111000
  - index 4: 110011
  - index 5: 011111
  - index 6: 001011
  - index 7: 000000
- Lookup: `rrggbb` <= palette[`color_index`] every cycle, unconditionally, including during writes and rotations.
- Host write port:
  - `wr_ready` = `vblank` & state==IDLE & !`rot_trigger`. This is combinational.
  - A transfer happens when `wr_valid`&`wr_ready`; palette[`wr_addr`] <= `wr_data` at that edge.
  - A requester holds `wr_valid`, `wr_addr` and `wr_data` stable until the transfer.
- Frame counter `fcnt`, width $clog2(`FRAMES_PER_STEP`) (minimum 1):
  - Held at 0 while `cycle_en`=0.
  - On a `vsync_start` with `cycle_en`=1: if `fcnt`==`FRAMES_PER_STEP`-1, assert `rot_trigger` and wrap `fcnt` to 0; otherwise increment.
- FSM states: IDLE, LOAD, SHIFT, STORE.
  - IDLE → LOAD on `rot_trigger`.
  - LOAD: `tmp` <= palette[`CYCLE_HI`]; `ptr` <= `CYCLE_HI`; go to SHIFT.
  - SHIFT: palette[`ptr`] <= palette[`ptr`-1]; `ptr` decrements. Go to STORE after the step where `ptr`==`CYCLE_LO`+1.
  - STORE: palette[`CYCLE_LO`] <= `tmp`; go to IDLE.
- Net effect of one rotation: each band entry moves up one index; the old `CYCLE_HI` entry wraps to `CYCLE_LO`. Entries outside the band are untouched.
- Arbitration: rotation always has priority. The host port is stalled via `wr_ready`=0 for the trigger cycle and for all non-IDLE states.
- A `rot_trigger` arriving while not in IDLE is dropped; `fcnt` still advances.
- `busy` = (state != IDLE).

## Timing
- Reset values:
  - `rrggbb` = 000000, `busy` = 0, state IDLE, `fcnt` = 0, `tmp` = 0.
  - Palette = defaults.
  - `wr_ready` = 0 in the reset cycle (forced low while `reset` is high).
- Lookup latency is 1 cycle. A write committed at edge N is visible on `rrggbb` at edge N+1 for a lookup issued in cycle N+1. There is no write-to-read bypass.
- Rotation length: `busy` is high for `CYCLE_HI`-`CYCLE_LO`+2 cycles (7 with defaults), starting the cycle after the triggering `vsync_start`.
- The rotation must finish inside blanking; this requires the vblank length to be ≥ 8 cycles.
- Simultaneous `wr_valid` and triggering `vsync_start`: the write is not accepted. It completes on the first IDLE cycle with `vblank`=1, landing on the post-rotation palette.
- `wr_valid` outside `vblank`: stalled until `vblank` rises. The host request is never lost.
- `reset` mid-rotation: the FSM aborts to IDLE, the palette returns to defaults, and `busy` is 0 on the next cycle.
- `cycle_en` deasserted mid-rotation: the rotation completes and `fcnt` clears to 0.

## Configuration
- Macro: `PALETTE_CYCLE_EN`.
- Defined: frame counter, rotation FSM and arbitration exactly as above.
- Undefined:
  - Frame counter and FSM are removed.
  - `cycle_en` is ignored and `busy` is tied to 0.
  - `wr_ready` = `vblank` & !`reset`.
  - The block is a plain writable palette; ports are unchanged.

## Test plan
- Reset, then sweep `color_index` 0..7 → `rrggbb` shows 111000, 110110, 101101, 111000, 110011, 011111, 001011, 000000, each one cycle after its index.
- `wr_valid`=1, `wr_addr`=7, `wr_data`=101010, with `vblank`=0 for 5 cycles then 1 → `wr_ready` stays 0, then the transfer happens in the first `vblank` cycle; index 7 then reads 101010.
- `FRAMES_PER_STEP`=2, `cycle_en`=1, two `vsync_start` pulses → `busy` high for exactly 7 cycles after the second pulse. Indices 1..6 then read 001011, 110110, 101101, 111000, 110011, 011111; index 0 reads 111000 and index 7 reads 000000.
- Host write (`wr_addr`=3, 000111) presented in the same cycle as the triggering `vsync_start` → `wr_ready`=0 until `busy` falls. Index 3 ends as 000111 and index 4 as 101101.
- Assert `reset` during the SHIFT state → the next cycle has `busy`=0 and all indices read the defaults; `fcnt` restarts, so the next rotation comes after `FRAMES_PER_STEP` further pulses.
- Build without `PALETTE_CYCLE_EN`, `cycle_en`=1, 16 `vsync_start` pulses → palette unchanged and `busy`=0 throughout; writes are accepted whenever `vblank`=1.
